// File: rtl/pc_lut_loader.sv
// Branch-target table (16 entries) filled from a byte stream, with a combinational addr->target lookup.
// Latency: an entry is written on the edge that accepts its high byte; lookups are combinational but read 0 until loaded.
// Backpressure: in_ready is high only in LO/HI; in_valid gaps stall the loader indefinitely with no state change.
module pc_lut_loader #(
    parameter int D = 12,
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    input  logic [3:0]   addr,
    output logic [D-1:0] target,
    output logic         loaded,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Bits of the high byte at or above this position lie outside the target width.
    localparam int          HiShift = D - 8;
    localparam logic [3:0]  LastIdx = 4'(N - 1);

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [7:0]     lo_hold_q, lo_hold_d;
    logic           err_q, err_d;
    logic           wr_en;
    logic [D-1:0]   wr_dat;
    logic [7:0]     hi_over_bits;
    logic [D-1:0]   table_q [N];

    // For D=16 the shift clears every bit, so the overflow check is empty.
    assign hi_over_bits = in_data >> HiShift;
    assign wr_dat       = {in_data[D-9:0], lo_hold_q};

    // Next-state and handshake outputs; defaults hold every register.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lo_hold_d = lo_hold_q;
        err_d     = err_q;
        wr_en     = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        loaded    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LO;
                    idx_d   = 4'd0;
                    err_d   = 1'b0;
                end
            end
            S_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    lo_hold_d = in_data;
                    state_d   = S_HI;
                end
            end
            S_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (|hi_over_bits) begin
                        err_d = 1'b1;
                    end
                    if (idx_q == LastIdx) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_LO;
                    end
                end
            end
            S_DONE: begin
                loaded = 1'b1;
                if (start) begin
                    state_d = S_LO;
                    idx_d   = 4'd0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers; reset returns to IDLE with a clean error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 4'd0;
            lo_hold_q <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lo_hold_q <= lo_hold_d;
            err_q     <= err_d;
        end
    end

    // Table storage; reset discards any partial load by zeroing every entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en) begin
            table_q[idx_q] <= wr_dat;
        end
    end

    assign err    = err_q;
    // Lookups are masked until the whole table has been written.
    assign target = loaded ? table_q[addr] : '0;

endmodule

// File: doc/pc_lut_loader.md
Name: pc_lut_loader

Overview:
Loader and read-port owner for the 16-entry branch-target table used by the fetch stage.
- Holds the table in registers and fills it at run time from a byte stream using a valid/ready handshake, so target values no longer have to be poked in by the testbench.
- Serves the fetch stage's combinational `addr -> target` lookup.
- Flags via `loaded` when the program may start fetching.

Parameters:
- D, 12: target width in bits (PC width). Legal range 9..16, because each entry is sent as two bytes.
- N, 16: number of entries. Fixed at 16 to match the 4-bit addr; any other value is illegal.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: single-cycle request to begin a full table load.
- in_valid, input, 1: a byte is present on in_data.
- in_data, input, 8: load byte stream.
- in_ready, output, 1: loader accepts a byte this cycle.
- addr, input, 4: lookup index from fetch/branch decode.
- target, output, D: table[addr] when loaded=1, else 0.
- loaded, output, 1: table completely written since the last start.
- busy, output, 1: a load is in progress.
- err, output, 1: sticky; set if any high byte carried nonzero bits above D-1.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, idx=0, lo_hold=0, all N entries=0.
  - loaded=0, busy=0, err=0, in_ready=0, target=0.
- Handshake: a byte is accepted on a rising edge where in_valid=1 and in_ready=1. in_ready depends only on state, never on in_valid.
- Byte order per entry, entries sent in index order 0..N-1:
  - First byte: target bits [7:0].
  - Second byte: bits [D-1:8] in in_data[D-9:0]. For D=12 this is in_data[3:0].
- States:
  - IDLE: in_ready=0, busy=0, loaded=0. start=1 -> LO, idx=0, err cleared.
  - LO: in_ready=1, busy=1. On accept, lo_hold<=in_data, go to HI.
  - HI: in_ready=1, busy=1.
    - On accept, table[idx] <= {in_data[D-9:0], lo_hold}.
    - If in_data[7:D-8] != 0, err<=1. For D=16 this check is empty. The entry is still written.
    - If idx==N-1, go to DONE; otherwise idx<=idx+1 and go to LO.
  - DONE: in_ready=0, busy=0, loaded=1.
    - start=1 -> LO, idx=0, loaded<=0, err<=0.
    - Existing entries are kept until overwritten.
- start while busy=1 (LO/HI) is ignored; the load continues unchanged.
- Gaps: in_valid=0 cycles stall in place with no state change and no timeout.
- target is combinational from addr and the registers.
  - An entry written at edge t is visible from t+ onward, but only once loaded=1.
  - loaded rises on the same edge that writes entry N-1, so the full table is readable the cycle after the last accept.
  - While loaded=0, target=0 regardless of addr or table contents.
- Total load: exactly 2N accepted bytes. The minimum is 32 cycles after the cycle start is sampled.
- Reset mid-load: immediate return to the reset state; a partial table is discarded (zeroed).
- in_data is ignored whenever no accept occurs.
- Width: the idx counter is 4 bits and never wraps past N-1, because DONE is entered first.

Test Plan:
- Reset: assert reset_n=0 asynchronously mid-cycle -> immediately loaded=0, busy=0, in_ready=0, err=0, and target=0 for addr=0..15.
- Full load, back-to-back:
  - Stimulus: start pulse, then 32 bytes encoding 0,37,64,72,79,16,14,1,0,0,0,0,0,0,0,4095 (e.g. entry 1 = 0x25,0x00; entry 15 = 0xFF,0x0F).
  - Response: loaded=1 exactly one cycle after the 32nd accept; addr=1 -> 37, addr=4 -> 79, addr=15 -> 4095; err=0.
- Backpressure gaps: same load with random 0-3 idle cycles of in_valid between bytes.
  - Response: identical final table, busy=1 throughout, no missed or duplicated byte.
- Error flag: entry 3 sent as 0x48,0x1F.
  - Response: err=1 (sticky), table[3]=0xF48=3912, load completes with loaded=1.
  - A new start clears err.
- Start handling:
  - start pulses during LO and HI are ignored, and the table still loads correctly.
  - After DONE, start drops loaded to 0 and target to 0.
  - Reloading new values updates the lookups to the new values.
- Reset mid-load: reset_n=0 after 10 accepted bytes -> all outputs return to reset values; a subsequent full load behaves as in the full-load scenario.
